counter_sequencer: RTL and testbench

- Sequencing controller for the WIDTH-bit incrementer plus reset-able register counter datapath.
- Accepts start commands over a valid/ready handshake and runs the counter from 0 up to a programmed limit.
- Emits a terminal-count strobe each time the limit is reached; one-shot commands also emit a completion pulse.
- Sits between a command source (CPU/config logic) and any logic that consumes periodic ticks or timed windows.

---
 rtl/counter_sequencer_pkg.sv | 13 +
 rtl/count_reg_inc.sv | 29 ++
 rtl/counter_sequencer.sv | 128 ++++++++++++
 tb/tb_counter_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and run modes.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_reg_inc.sv
// WIDTH-bit counter register with synchronous reset, clear and enable.
// Exposes both the current value and its increment so the controller
// can compare against the limit without a second adder.
module count_reg_inc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_inc
);

  // Incrementer; truncation to WIDTH bits is intentional.
  always_comb begin
    count_inc = count + WIDTH'(1);
  end

  // Register: reset and clear dominate, enable loads the increment.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencing controller for a limit counter. Accepts a start command over a
// valid/ready handshake, counts 0..limit, strobes tick at the terminal count,
// and either restarts (periodic) or pulses done and returns to idle (one-shot).
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_mode,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic [WIDTH-1:0] count_inc;
  logic             transfer;
  logic             terminal;
  logic             cnt_clr;
  logic             cnt_en;

  // Handshake and terminal-count decode, shared by both comb processes.
  always_comb begin
    transfer = cmd_valid && !RESET && (state_q == ST_IDLE);
    terminal = (count == limit_q);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture: limit and mode are only sampled on a transfer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
    end else if (transfer) begin
      limit_q <= cmd_limit;
      mode_q  <= cmd_mode;
    end
  end

  // Next-state logic; stop takes priority over the terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (terminal && (mode_q == MODE_ONESHOT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and counter controls, decoded from registered state plus stop.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    tick      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Ready is withheld during reset so a handshake can never appear to complete.
        cmd_ready = !RESET;
        cnt_clr   = transfer;
      end
      ST_RUN: begin
        busy = 1'b1;
        tick = terminal && !stop;
        if (!stop) begin
          cnt_en  = !terminal;
          cnt_clr = terminal && (mode_q == MODE_PERIODIC);
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  count_reg_inc #(
    .WIDTH(WIDTH)
  ) u_count (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count    (count),
    .count_inc(count_inc)
  );

  // The increment is consumed inside the counter; the comparison uses count directly.
  logic unused_count_inc;
  assign unused_count_inc = ^count_inc;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_counter_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_limit;
  logic       cmd_mode;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  typedef struct {
    string      name;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  counter_sequencer #(
    .WIDTH(4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_limit(cmd_limit),
    .cmd_mode (cmd_mode),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  // Monitor: compare one expected record per cycle, away from the rising edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (count !== e.count || busy !== e.busy || tick !== e.tick ||
          done !== e.done || cmd_ready !== e.ready) begin
        errors++;
        $display("FAIL %s: got count=%0d busy=%b tick=%b done=%b ready=%b, want count=%0d busy=%b tick=%b done=%b ready=%b",
                 e.name, count, busy, tick, done, cmd_ready,
                 e.count, e.busy, e.tick, e.done, e.ready);
      end
    end
  end

  task automatic push(input string n, input int c, input logic b, input logic t,
                      input logic d, input logic r);
    exp_t e;
    e.name  = n;
    e.count = 4'(c);
    e.busy  = b;
    e.tick  = t;
    e.done  = d;
    e.ready = r;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input string n, input int c);
    push(n, c, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic exp_run(input string n, input int c, input logic t);
    push(n, c, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic exp_done(input string n, input int c);
    push(n, c, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int lim, input logic mode);
    cmd_valid = 1'b1;
    cmd_limit = 4'(lim);
    cmd_mode  = mode;
  endtask

  initial begin
    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_limit = 4'd0;
    cmd_mode  = 1'b0;
    stop      = 1'b0;
    cyc();
    cyc();
    RESET = 1'b0;
    exp_idle("reset", 0);
    cyc();

    // One-shot, limit 5.
    send(5, 1'b0);
    exp_idle("os5_xfer", 0);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      exp_run("os5_run", i, i == 5);
      cyc();
    end
    exp_done("os5_done", 5);
    cyc();
    exp_idle("os5_idle", 5);
    cyc();

    // Periodic, limit 3, twelve run cycles, then stop.
    send(3, 1'b1);
    exp_idle("per3_xfer", 5);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_run("per3_run", i % 4, (i % 4) == 3);
      cyc();
    end
    stop = 1'b1;
    exp_run("per3_stop", 0, 1'b0);
    cyc();
    stop = 1'b0;
    exp_idle("per3_idle", 0);
    cyc();

    // One-shot, limit 15: full range without wrap.
    send(15, 1'b0);
    exp_idle("os15_xfer", 0);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i <= 15; i++) begin
      exp_run("os15_run", i, i == 15);
      cyc();
    end
    exp_done("os15_done", 15);
    cyc();
    exp_idle("os15_idle", 15);
    cyc();

    // One-shot, limit 0.
    send(0, 1'b0);
    exp_idle("os0_xfer", 15);
    cyc();
    cmd_valid = 1'b0;
    exp_run("os0_run", 0, 1'b1);
    cyc();
    exp_done("os0_done", 0);
    cyc();
    exp_idle("os0_idle", 0);
    cyc();

    // cmd_valid held through RUN/DONE; second command (limit 1) taken in IDLE.
    send(2, 1'b0);
    exp_idle("hold_xfer", 0);
    cyc();
    send(1, 1'b0);
    exp_run("hold_run", 0, 1'b0);
    cyc();
    exp_run("hold_run", 1, 1'b0);
    cyc();
    exp_run("hold_run", 2, 1'b1);
    cyc();
    exp_done("hold_done", 2);
    cyc();
    exp_idle("hold_xfer2", 2);
    cyc();
    cmd_valid = 1'b0;
    exp_run("hold_run2", 0, 1'b0);
    cyc();
    exp_run("hold_run2", 1, 1'b1);
    cyc();
    exp_done("hold_done2", 1);
    cyc();
    exp_idle("hold_idle2", 1);
    cyc();

    // Periodic limit 7, stop at count 4.
    send(7, 1'b1);
    exp_idle("stop4_xfer", 1);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_run("stop4_run", i, 1'b0);
      cyc();
    end
    stop = 1'b1;
    exp_run("stop4_at", 4, 1'b0);
    cyc();
    exp_idle("stop4_idle", 4);
    cyc();
    stop = 1'b0;

    // Periodic limit 7, stop coincident with terminal count.
    send(7, 1'b1);
    exp_idle("stop7_xfer", 4);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_run("stop7_run", i, 1'b0);
      cyc();
    end
    stop = 1'b1;
    exp_run("stop7_at", 7, 1'b0);
    cyc();
    stop = 1'b0;
    exp_idle("stop7_idle", 7);
    cyc();
    exp_idle("stop7_idle2", 7);
    cyc();

    // RESET during a one-shot run at count 6.
    send(7, 1'b0);
    exp_idle("rst6_xfer", 7);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_run("rst6_run", i, 1'b0);
      cyc();
    end
    RESET = 1'b1;
    exp_run("rst6_at", 6, 1'b0);
    cyc();
    RESET = 1'b0;
    exp_idle("rst6_idle", 0);
    cyc();
    exp_idle("rst6_nodone", 0);
    cyc();

    // RESET with cmd_valid in IDLE: no transfer.
    RESET = 1'b1;
    send(3, 1'b1);
    push("rst_xfer_blocked", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    RESET = 1'b0;
    cmd_valid = 1'b0;
    exp_idle("rst_xfer_idle", 0);
    cyc();
    exp_idle("rst_xfer_idle2", 0);
    cyc();

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge CLK);
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, want 0", sb.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
